// File: rtl/dmem_responder.sv
// dmem_responder: RV32 data-memory responder with wait states and a sticky done flag
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] DONE_ADDR   = 32'h000000FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        done
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t      state, state_n;
  logic [3:0]  cnt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic        accept, exec;
  logic        x_we;
  logic [2:0]  x_f3;
  logic [31:0] x_addr, x_wdata;
  logic        bad_f3, misal, oor, hit_done, x_err;
  logic [31:0] word, shifted, wsh, ld_data, st_word;
  logic [3:0]  be;
  // State register
  always_ff @(posedge clk)
    state <= !reset ? S_IDLE : state_n;
  // Next state and handshake outputs; execute fires on every edge that enters RESP
  always_comb begin
    req_ready  = state == S_IDLE;
    resp_valid = state == S_RESP;
    accept     = req_ready && req_valid;
    state_n    = accept ? (WAIT_CYCLES == 0 ? S_RESP : S_WAIT) :
                 (state == S_WAIT && cnt == 4'd0) ? S_RESP :
                 (state == S_RESP && resp_ready) ? S_IDLE : state;
    exec       = state_n == S_RESP && state != S_RESP;
  end
  // Access decode; with zero wait states the request executes straight from the ports
  always_comb begin
    x_we     = state == S_IDLE ? req_we : we_q;
    x_f3     = state == S_IDLE ? req_funct3 : f3_q;
    x_addr   = state == S_IDLE ? req_addr : addr_q;
    x_wdata  = state == S_IDLE ? req_wdata : wdata_q;
    bad_f3   = x_we ? x_f3 > 3'd2 : (x_f3 == 3'd3 || x_f3[2:1] == 2'b11);
    misal    = (x_f3[1:0] == 2'b01 && x_addr[0]) || (x_f3[1:0] == 2'b10 && x_addr[1:0] != 2'b00);
    oor      = x_addr[31:2] >= 30'(DEPTH_WORDS);
    hit_done = x_we && !bad_f3 && x_addr == DONE_ADDR;
    x_err    = !hit_done && (bad_f3 || misal || oor);
    word     = mem[x_addr[AW+1:2]];
    shifted  = word >> {x_addr[1:0], 3'b000};
    wsh      = x_wdata << {x_addr[1:0], 3'b000};
    ld_data  = x_f3[1:0] == 2'b00 ? {{24{shifted[7] & ~x_f3[2]}}, shifted[7:0]} :
               x_f3[1:0] == 2'b01 ? {{16{shifted[15] & ~x_f3[2]}}, shifted[15:0]} : word;
    be       = x_f3[1:0] == 2'b00 ? 4'b0001 << x_addr[1:0] :
               x_f3[1:0] == 2'b01 ? 4'b0011 << {x_addr[1], 1'b0} : 4'b1111;
    st_word  = word;
    for (int k = 0; k < 4; k++)
      st_word[8*k+:8] = be[k] ? wsh[8*k+:8] : word[8*k+:8];
  end
  // Backing array is written only at the execute edge, and never while in reset
  always_ff @(posedge clk)
    if (reset && exec && x_we && !x_err && !hit_done)
      mem[x_addr[AW+1:2]] <= st_word;
  // Request capture, wait counter and response/done registers
  always_ff @(posedge clk)
    if (!reset) begin
      cnt        <= 4'd0;
      we_q       <= 1'b0;
      f3_q       <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end else if (state == S_WAIT && cnt != 4'd0)
        cnt <= cnt - 4'd1;
      if (exec) begin
        resp_rdata <= (x_we || x_err) ? 32'd0 : ld_data;
        resp_err   <= x_err;
        done       <= done | hit_done;
      end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: byte-level model bench for dmem_responder at 1, 0 and 3 wait states
module tb_dmem_responder;
  localparam int          DEPTH  = 1024;
  localparam logic [31:0] DONE_A = 32'h000000FF;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  rv, rr, respv, respr, err, dn;
  logic [31:0] rdata [3];
  int          checks = 0;
  int          fails = 0;
  bit          started = 1'b0;
  logic [7:0]  mb [3][4*DEPTH];
  logic [31:0] exp_rdata [3];
  logic        exp_err [3];
  logic        exp_done [3];
  logic        done_m [3];
  logic        pend [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS(DEPTH),
      .WAIT_CYCLES(g == 0 ? 1 : g == 1 ? 0 : 3),
      .DONE_ADDR(DONE_A)
    ) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(rv[g]), .req_ready(rr[g]), .req_we(req_we), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(respv[g]), .resp_ready(respr[g]), .resp_rdata(rdata[g]),
      .resp_err(err[g]), .done(dn[g])
    );
  end

  function automatic int wv(int i);
    return i == 0 ? 1 : i == 1 ? 0 : 3;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: memory as bytes, access rules applied directly
  function automatic void model(int i, bit we, bit [2:0] f3, bit [31:0] a, bit [31:0] wd);
    int sz;
    bit bad, hit;
    bit [31:0] v;
    sz  = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    bad = we ? f3 > 3'd2 : (f3 == 3'd3 || f3 > 3'd5);
    hit = we && !bad && a == DONE_A;
    exp_done[i]  = done_m[i] | hit;
    exp_err[i]   = 1'b0;
    exp_rdata[i] = 32'd0;
    if (!hit) begin
      if (bad || (a % sz) != 0 || a / 4 >= DEPTH) exp_err[i] = 1'b1;
      else if (we) for (int k = 0; k < sz; k++) mb[i][a+k] = wd[8*k+:8];
      else begin
        v = 32'd0;
        for (int k = 0; k < sz; k++) v |= 32'(mb[i][a+k]) << (8*k);
        if (!f3[2] && sz < 4 && v[8*sz-1]) v |= 32'hFFFFFFFF << (8*sz);
        exp_rdata[i] = v;
      end
    end
  endfunction

  // Every cycle: responses must match the model and be expected; done must track the model
  always @(negedge clk)
    if (started)
      for (int i = 0; i < 3; i++)
        if (respv[i]) begin
          chk("resp_expected", 32'(pend[i]), 32'd1);
          chk("resp_rdata", rdata[i], exp_rdata[i]);
          chk("resp_err", 32'(err[i]), 32'(exp_err[i]));
          chk("resp_done", 32'(dn[i]), 32'(exp_done[i]));
          chk("req_ready_in_resp", 32'(rr[i]), 32'd0);
        end else
          chk("done_idle", 32'(dn[i]), 32'(done_m[i]));

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      done_m[i] = 1'b0;
      pend[i] = 1'b0;
      chk("rst_req_ready", 32'(rr[i]), 32'd1);
      chk("rst_resp_valid", 32'(respv[i]), 32'd0);
      chk("rst_rdata", rdata[i], 32'd0);
      chk("rst_err", 32'(err[i]), 32'd0);
      chk("rst_done", 32'(dn[i]), 32'd0);
    end
  endtask

  task automatic access(int i, bit we, bit [2:0] f3, bit [31:0] a, bit [31:0] wd, int hold,
                        output logic [31:0] got, output logic got_err);
    int n;
    model(i, we, f3, a, wd);
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; rv[i] = 1'b1;
    n = 0;
    while (!rr[i] && n < 20) begin @(negedge clk); n++; end
    chk("accept_wait", 32'(n < 20), 32'd1);
    @(posedge clk);
    #1;
    rv[i] = 1'b0;
    pend[i] = 1'b1;
    req_we = 1'($urandom_range(0, 1)); req_funct3 = 3'($urandom_range(0, 7));
    req_addr = $urandom; req_wdata = $urandom;
    n = 1;
    while (!respv[i] && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency", 32'(n), 32'(wv(i) + 1));
    got = rdata[i];
    got_err = err[i];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'hFFFFFFFF; rv[i] = 1'b1;
    end
    @(negedge clk);
    rv[i] = 1'b0;
    respr[i] = 1'b1;
    @(posedge clk);
    #1;
    respr[i] = 1'b0;
    pend[i] = 1'b0;
    done_m[i] = exp_done[i];
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    logic        ge;
    bit [2:0]    lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    rv = 3'd0; respr = 3'd0;
    req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 3; i++) begin
      done_m[i] = 1'b0; pend[i] = 1'b0; exp_rdata[i] = 32'd0; exp_err[i] = 1'b0; exp_done[i] = 1'b0;
      for (int b = 0; b < 4*DEPTH; b++) mb[i][b] = 8'd0;
    end
    repeat (2) @(posedge clk);
    do_reset();
    started = 1'b1;
    access(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0, got, ge);
    chk("sw_err", 32'(ge), 32'd0);
    access(0, 0, 3'd2, 32'h10, 0, 0, got, ge);
    chk("lw10", got, 32'hDEADBEEF);
    access(0, 0, 3'd0, 32'h13, 0, 0, got, ge);
    chk("lb13", got, 32'hFFFFFFDE);
    access(0, 0, 3'd4, 32'h13, 0, 0, got, ge);
    chk("lbu13", got, 32'h000000DE);
    access(0, 0, 3'd1, 32'h10, 0, 0, got, ge);
    chk("lh10", got, 32'hFFFFBEEF);
    access(0, 0, 3'd5, 32'h12, 0, 0, got, ge);
    chk("lhu12", got, 32'h0000DEAD);
    access(0, 1, 3'd0, 32'h11, 32'h55, 0, got, ge);
    access(0, 0, 3'd2, 32'h10, 0, 0, got, ge);
    chk("lw10_after_sb", got, 32'hDEAD55EF);
    access(0, 0, 3'd2, 32'h12, 0, 0, got, ge);
    chk("lw_misal_err", 32'(ge), 32'd1);
    chk("lw_misal_rdata", got, 32'd0);
    access(0, 1, 3'd1, 32'h11, 32'hAAAA, 0, got, ge);
    chk("sh_misal_err", 32'(ge), 32'd1);
    access(0, 0, 3'd2, 32'h10, 0, 0, got, ge);
    chk("lw10_unchanged", got, 32'hDEAD55EF);
    access(0, 0, 3'd2, 32'(4*DEPTH), 0, 0, got, ge);
    chk("lw_oor_err", 32'(ge), 32'd1);
    access(0, 0, 3'd3, 32'h10, 0, 0, got, ge);
    chk("ld_f3_011_err", 32'(ge), 32'd1);
    access(0, 1, 3'd3, 32'h10, 32'h1, 0, got, ge);
    chk("st_f3_011_err", 32'(ge), 32'd1);
    access(0, 0, 3'd2, 32'h10, 0, 5, got, ge);
    chk("hold_rdata", got, 32'hDEAD55EF);
    access(0, 0, 3'd2, 32'h10, 0, 0, got, ge);
    chk("lw10_after_hold", got, 32'hDEAD55EF);
    for (int w = 0; w < 4; w++) access(0, 1, 3'd2, 32'(32'h40 + 4*w), 32'd0, 0, got, ge);
    access(0, 1, 3'd2, DONE_A, 32'h1, 0, got, ge);
    chk("done_set", 32'(dn[0]), 32'd1);
    chk("done_store_err", 32'(ge), 32'd0);
    for (int r = 0; r < 20; r++)
      access(0, 1'($urandom_range(0, 1)), lf3[$urandom_range(0, 4)], 32'(32'h40 + $urandom_range(0, 15)),
             $urandom, 0, got, ge);
    chk("done_sticky", 32'(dn[0]), 32'd1);
    do_reset();
    access(0, 1, 3'd2, 32'h20, 32'd0, 0, got, ge);
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h12345678; rv[0] = 1'b1;
    @(posedge clk);
    #1;
    rv[0] = 1'b0;
    reset = 1'b0;
    chk("in_wait_req_ready", 32'(rr[0]), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("abort_idle", 32'(rr[0]), 32'd1);
    chk("abort_no_resp", 32'(respv[0]), 32'd0);
    access(0, 0, 3'd2, 32'h20, 0, 0, got, ge);
    chk("lw20_not_written", got, 32'd0);
    for (int i = 1; i < 3; i++) begin
      access(i, 1, 3'd2, 32'h30, 32'hCAFEF00D, 0, got, ge);
      access(i, 0, 3'd2, 32'h30, 0, 0, got, ge);
      chk("sweep_lw30", got, 32'hCAFEF00D);
      access(i, 0, 3'd1, 32'h32, 0, 0, got, ge);
      chk("sweep_lh32", got, 32'hFFFFCAFE);
    end
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
